alu_md_sequencer: RTL and testbench

//  Multi-cycle MULTU/DIVU engine that borrows the shared 32-bit ALU through ALUOp/ALUA/ALUB and reads ALUResult.

---
 rtl/alu_md_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_md_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_md_sequencer.sv
// Multi-cycle MULTU/DIVU engine that borrows the shared 32-bit ALU; results land in HI/LO.
// Optional feature: define MD_EARLY_OUT_EN for MULTU early termination (M_FIX state).
`ifndef ALU_ADD
`define ALU_ADD  3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB  3'd1
`endif
`ifndef ALU_CMPU
`define ALU_CMPU 3'd2
`endif

module alu_md_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [31:0] ALUResult,
  output logic [2:0]  ALUOp,
  output logic [31:0] ALUA,
  output logic [31:0] ALUB,
  output logic        AluOwn,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {IDLE, M_ADD, M_CARRY, D_CMP, D_SUB, M_FIX, DONE} state_t;

  state_t      state, next;
  logic [31:0] hi, lo, breg, t;
  logic [4:0]  cnt;
  logic        lt, dbz;
  logic [31:0] r;
  logic        ovf;

  // Partial remainder after shifting in the next dividend bit; ovf is its 33rd bit.
  assign r   = {hi[30:0], lo[31]};
  assign ovf = hi[31];

`ifdef MD_EARLY_OUT_EN
  logic        early;
  logic [63:0] fix;
  // Remaining multiplier bits all zero: the rest of the loop would only shift.
  assign early = ((lo & (32'hFFFF_FFFF >> cnt)) == 32'd0);
  assign fix   = {hi, lo} >> (6'd32 - {1'b0, cnt});
`endif

  always_comb begin
    next   = state;
    ALUOp  = `ALU_ADD;
    ALUA   = 32'd0;
    ALUB   = 32'd0;
    AluOwn = 1'b0;
    case (state)
      IDLE:
        if (Start) next = !Op ? M_ADD : (OpB == 32'd0 ? DONE : D_CMP);
      M_ADD: begin
        AluOwn = 1'b1;
`ifdef MD_EARLY_OUT_EN
        if (early) next = M_FIX;
        else begin
          ALUA = hi;
          ALUB = lo[0] ? breg : 32'd0;
          next = M_CARRY;
        end
`else
        ALUA = hi;
        ALUB = lo[0] ? breg : 32'd0;
        next = M_CARRY;
`endif
      end
      M_CARRY: begin
        AluOwn = 1'b1;
        ALUOp  = `ALU_CMPU;
        ALUA   = t;
        ALUB   = hi;
        next   = (cnt == 5'd31) ? DONE : M_ADD;
      end
      D_CMP: begin
        AluOwn = 1'b1;
        ALUOp  = `ALU_CMPU;
        ALUA   = r;
        ALUB   = breg;
        next   = D_SUB;
      end
      D_SUB: begin
        AluOwn = 1'b1;
        ALUOp  = `ALU_SUB;
        ALUA   = r;
        ALUB   = breg;
        next   = (cnt == 5'd31) ? DONE : D_CMP;
      end
`ifdef MD_EARLY_OUT_EN
      M_FIX: begin
        AluOwn = 1'b1;
        next   = DONE;
      end
`endif
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      breg  <= 32'd0;
      t     <= 32'd0;
      cnt   <= 5'd0;
      lt    <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE:
          if (Start) begin
            breg <= OpB;
            dbz  <= 1'b0;
            cnt  <= 5'd0;
            if (Op && OpB == 32'd0) begin
              hi  <= OpA;
              lo  <= 32'hFFFF_FFFF;
              dbz <= 1'b1;
            end else begin
              hi <= 32'd0;
              lo <= OpA;
            end
          end
        M_ADD: t <= ALUResult;
        M_CARRY: begin
          // Carry out of the add is recovered as (sum < old HI).
          hi  <= {ALUResult[0], t[31:1]};
          lo  <= {t[0], lo[31:1]};
          cnt <= cnt + 5'd1;
        end
        D_CMP: lt <= ALUResult[0] & ~ovf;
        D_SUB: begin
          hi  <= lt ? r : ALUResult;
          lo  <= {lo[30:0], ~lt};
          cnt <= cnt + 5'd1;
        end
`ifdef MD_EARLY_OUT_EN
        M_FIX: {hi, lo} <= fix;
`endif
        default: ;
      endcase
    end
  end

  assign Busy      = (state != IDLE) && (state != DONE);
  assign Done      = (state == DONE);
  assign DivByZero = dbz;
  assign HI        = hi;
  assign LO        = lo;

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Directed bench for alu_md_sequencer with a behavioural model of the shared ALU.
module tb_alu_md_sequencer;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_CMPU = 3'd2;

  logic        CLK = 1'b0;
  logic        Reset, Start, Op;
  logic [31:0] OpA, OpB, ALUResult;
  logic [2:0]  ALUOp;
  logic [31:0] ALUA, ALUB, HI, LO;
  logic        AluOwn, Busy, Done, DivByZero;

  int checks = 0, passed = 0;
  int lat, dcount;

  always #5 CLK = ~CLK;

  always_comb begin
    ALUResult = 32'd0;
    case (ALUOp)
      A_ADD:  ALUResult = ALUA + ALUB;
      A_SUB:  ALUResult = ALUA - ALUB;
      A_CMPU: ALUResult = {31'd0, ALUA < ALUB};
      default: ALUResult = 32'd0;
    endcase
  end

  alu_md_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .ALUResult(ALUResult), .ALUOp(ALUOp), .ALUA(ALUA), .ALUB(ALUB),
    .AluOwn(AluOwn), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HI(HI), .LO(LO)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    Op = op; OpA = a; OpB = b; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  // Latency counts the accepting edge as cycle 1; bounded wait.
  task automatic wait_done(input int l0, output int l);
    l = l0;
    while (!Done && l < 200) begin
      step();
      l++;
    end
  endtask

  task automatic run(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int elat);
    int l;
    start_op(op, a, b);
    wait_done(1, l);
    check({tag, "_done"}, {31'd0, Done}, 32'd1);
    check({tag, "_hi"}, HI, ehi);
    check({tag, "_lo"}, LO, elo);
    check({tag, "_dbz"}, {31'd0, DivByZero}, {31'd0, edbz});
    check({tag, "_lat"}, l, elat);
    step();
    check({tag, "_pulse"}, {30'd0, Done, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; OpA = 32'd0; OpB = 32'd0;
    step(); step();
    check("rst_busy",  {31'd0, Busy}, 32'd0);
    check("rst_done",  {31'd0, Done}, 32'd0);
    check("rst_own",   {31'd0, AluOwn}, 32'd0);
    check("rst_dbz",   {31'd0, DivByZero}, 32'd0);
    check("rst_hi",    HI, 32'd0);
    check("rst_lo",    LO, 32'd0);
    check("rst_aluop", {29'd0, ALUOp}, {29'd0, A_ADD});
    check("rst_alua",  ALUA, 32'd0);
    check("rst_alub",  ALUB, 32'd0);
    Reset = 1'b0;
    step();

    // MULTU max*max, with a look at the first ALU request
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_own",   {31'd0, AluOwn}, 32'd1);
    check("mul_busy",  {31'd0, Busy}, 32'd1);
    check("mul_aluop", {29'd0, ALUOp}, {29'd0, A_ADD});
    check("mul_alua",  ALUA, 32'd0);
    check("mul_alub",  ALUB, 32'hFFFF_FFFF);
    wait_done(1, lat);
    check("mulmax_hi",  HI, 32'hFFFF_FFFE);
    check("mulmax_lo",  LO, 32'h0000_0001);
    check("mulmax_lat", lat, 65);
    step();
    check("mulmax_pulse", {31'd0, Done}, 32'd0);

    run("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 65);
    run("div_ovf", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 65);
    run("div5_9", 1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 65);
    run("div0", 1'b1, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1'b1, 1);

    // Next accepted start must clear the sticky flag
    start_op(1'b0, 32'd6, 32'd2);
    check("dbz_clear", {31'd0, DivByZero}, 32'd0);
    wait_done(1, lat);
    check("mul6_2_hi", HI, 32'd0);
    check("mul6_2_lo", LO, 32'd12);
`ifdef MD_EARLY_OUT_EN
    check("mul6_2_early", {31'd0, lat < 65}, 32'd1);
`else
    check("mul6_2_lat", lat, 65);
`endif
    step();

    // Start pulse while busy and operand changes are ignored
    start_op(1'b0, 32'd3, 32'd5);
    step(); step(); step();
    Op = 1'b1; OpA = 32'd100; OpB = 32'd7; Start = 1'b1;
    step();
    Start = 1'b0; OpA = 32'd9; OpB = 32'd9;
    wait_done(5, lat);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd15);
`ifndef MD_EARLY_OUT_EN
    check("ign_lat", lat, 65);
`endif
    // Start during DONE is ignored too
    Op = 1'b0; OpA = 32'd7; OpB = 32'd7; Start = 1'b1;
    step();
    Start = 1'b0;
    check("done_start_busy", {31'd0, Busy}, 32'd0);
    step();
    check("done_start_idle", {31'd0, Busy}, 32'd0);
    check("done_start_lo", LO, 32'd15);

    // Reset mid-operation aborts without a Done
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 19; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_own",  {31'd0, AluOwn}, 32'd0);
    check("abort_hi",   HI, 32'd0);
    check("abort_lo",   LO, 32'd0);
    dcount = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (Done || Busy) dcount++;
    end
    check("abort_quiet", dcount, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
